scan_ctrl_regs: RTL and testbench

Downstream consumer of the USB command parser: takes each validated `address`/`data`/`cmdvalid` command, updates the scan configuration registers and runs the transmit-trigger sequencer for the ultrasonic front end. It drives the acquisition engine's configuration and a periodic one-cycle `trig`. It counts shots, handles stop/abort, and reports completion, overrun and command errors.

---
 rtl/scan_ctrl_regs.sv | 152 +++++++++++++++
 tb/tb_scan_ctrl_regs.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl_regs.sv
// Scan configuration registers and transmit-trigger sequencer for the ultrasonic front end.
// Commands from the USB parser program the scan, start/stop runs and pace one-cycle triggers.
module scan_ctrl_regs #(
  parameter int unsigned DEF_DEPTH  = 1024,
  parameter int unsigned DEF_PERIOD = 50000,
  parameter int unsigned MIN_PERIOD = 16,
  parameter logic [7:0]  DEF_GAIN   = 8'h40
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  address,
  input  logic [31:0] data,
  input  logic        cmdvalid,
  input  logic        acq_busy,
  output logic [23:0] sample_depth,
  output logic [7:0]  gain,
  output logic [3:0]  channel,
  output logic        trig,
  output logic        busy,
  output logic        run_done,
  output logic        overrun,
  output logic        cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_DEPTH  = 8'h01;
  localparam logic [7:0] A_PERIOD = 8'h02;
  localparam logic [7:0] A_COUNT  = 8'h03;
  localparam logic [7:0] A_GAIN   = 8'h04;
  localparam logic [7:0] A_CHAN   = 8'h05;

  state_e      state_q;
  logic [23:0] depth_q;
  logic [7:0]  gain_q;
  logic [3:0]  chan_q;
  logic [31:0] period_q;
  logic [15:0] count_q;
  logic [31:0] pcnt_q;
  logic [15:0] shots_q;
  logic        trig_q, busy_q, run_done_q, overrun_q, cmd_err_q;

  logic        addr_ok, ctrl_wr, cfg_wr, start_cmd, stop_cmd, cmd_err_d, tick;
  logic [31:0] period_d;
  logic [15:0] shots_d;

  always_comb begin
    addr_ok   = address < 8'h06;
    ctrl_wr   = cmdvalid && (address == A_CTRL);
    // Configuration is frozen while busy, so the run keeps using the values it started with.
    cfg_wr    = cmdvalid && addr_ok && (address != A_CTRL) && !busy_q;
    start_cmd = ctrl_wr && data[0] && !data[1];
    stop_cmd  = ctrl_wr && data[1];
    cmd_err_d = cmdvalid && (!addr_ok
                             || ((address != A_CTRL) && busy_q)
                             || ((address == A_CTRL) && data[0] && !data[1] && busy_q));
    period_d  = (data < MIN_PERIOD) ? MIN_PERIOD : data;
    tick      = (pcnt_q == 32'd0);
    shots_d   = shots_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      depth_q  <= 24'(DEF_DEPTH);
      gain_q   <= DEF_GAIN;
      chan_q   <= 4'd0;
      period_q <= 32'(DEF_PERIOD);
      count_q  <= 16'd0;
    end else if (cfg_wr) begin
      case (address)
        A_DEPTH:  depth_q  <= data[23:0];
        A_PERIOD: period_q <= period_d;
        A_COUNT:  count_q  <= data[15:0];
        A_GAIN:   gain_q   <= data[7:0];
        A_CHAN:   chan_q   <= data[3:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      pcnt_q     <= 32'd0;
      shots_q    <= 16'd0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
      overrun_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      trig_q     <= 1'b0;
      run_done_q <= 1'b0;
      cmd_err_q  <= cmd_err_d;
      case (state_q)
        S_IDLE: begin
          if (start_cmd) begin
            // A one-shot run goes straight to DRAIN after its first trigger.
            state_q   <= (count_q == 16'd1) ? S_DRAIN : S_RUN;
            trig_q    <= 1'b1;
            busy_q    <= 1'b1;
            shots_q   <= 16'd1;
            pcnt_q    <= period_q - 32'd1;
            overrun_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop_cmd) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!tick) begin
            pcnt_q <= pcnt_q - 32'd1;
          end else if (acq_busy) begin
            overrun_q <= 1'b1;
          end else begin
            trig_q  <= 1'b1;
            shots_q <= shots_d;
            pcnt_q  <= period_q - 32'd1;
            if ((count_q != 16'd0) && (shots_d == count_q)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (stop_cmd) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!tick) begin
            pcnt_q <= pcnt_q - 32'd1;
          end else if (!acq_busy) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            run_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_depth = depth_q;
  assign gain         = gain_q;
  assign channel      = chan_q;
  assign trig         = trig_q;
  assign busy         = busy_q;
  assign run_done     = run_done_q;
  assign overrun      = overrun_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_scan_ctrl_regs.sv
// Directed bench for scan_ctrl_regs: register writes, finite/continuous runs, clamp, stall, errors, reset.
// Pulse outputs are scoreboarded by expected cycle number; levels are checked inline.
module tb_scan_ctrl_regs;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  address;
  logic [31:0] data;
  logic        cmdvalid;
  logic        acq_busy;
  logic [23:0] sample_depth;
  logic [7:0]  gain;
  logic [3:0]  channel;
  logic        trig, busy, run_done, overrun, cmd_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int trig_exp[$];
  int done_exp[$];
  int err_exp[$];
  int e_trig, e_done, e_err;
  int n;

  scan_ctrl_regs dut (
    .Clk(Clk), .Reset_n(Reset_n), .address(address), .data(data),
    .cmdvalid(cmdvalid), .acq_busy(acq_busy), .sample_depth(sample_depth),
    .gain(gain), .channel(channel), .trig(trig), .busy(busy),
    .run_done(run_done), .overrun(overrun), .cmd_err(cmd_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; holds the command for exactly one cycle.
  task automatic send(input logic [7:0] a, input logic [31:0] d);
    address  = a;
    data     = d;
    cmdvalid = 1'b1;
    @(posedge Clk);
    #1;
    cmdvalid = 1'b0;
    address  = 8'h00;
    data     = 32'h0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Pulse scoreboard: each observed pulse must match the oldest expected cycle.
  always @(negedge Clk) if (mon_en) begin
    if (trig === 1'b1) begin
      checks++;
      if (trig_exp.size() == 0) begin
        errors++; $error("FAIL trig: unexpected pulse at cycle %0d", cyc);
      end else begin
        e_trig = trig_exp.pop_front();
        assert (cyc === e_trig) else begin
          errors++; $error("FAIL trig: observed cycle %0d expected cycle %0d", cyc, e_trig);
        end
      end
    end
    if (run_done === 1'b1) begin
      checks++;
      if (done_exp.size() == 0) begin
        errors++; $error("FAIL run_done: unexpected pulse at cycle %0d", cyc);
      end else begin
        e_done = done_exp.pop_front();
        assert (cyc === e_done) else begin
          errors++; $error("FAIL run_done: observed cycle %0d expected cycle %0d", cyc, e_done);
        end
      end
    end
    if (cmd_err === 1'b1) begin
      checks++;
      if (err_exp.size() == 0) begin
        errors++; $error("FAIL cmd_err: unexpected pulse at cycle %0d", cyc);
      end else begin
        e_err = err_exp.pop_front();
        assert (cyc === e_err) else begin
          errors++; $error("FAIL cmd_err: observed cycle %0d expected cycle %0d", cyc, e_err);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_depth"},   32'(sample_depth), 32'd1024);
    chk({tag, "_gain"},    32'(gain),         32'h40);
    chk({tag, "_chan"},    32'(channel),      32'd0);
    chk({tag, "_trig"},    32'(trig),         32'd0);
    chk({tag, "_busy"},    32'(busy),         32'd0);
    chk({tag, "_done"},    32'(run_done),     32'd0);
    chk({tag, "_overrun"}, 32'(overrun),      32'd0);
    chk({tag, "_cmderr"},  32'(cmd_err),      32'd0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    address  = 8'h00;
    data     = 32'h0;
    cmdvalid = 1'b0;
    acq_busy = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk_reset_vals("rst");
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge Clk);
    #1;

    // Back-to-back config writes, each visible the cycle after its strobe.
    send(8'h01, 32'h0000_0800); chk("depth_wr", 32'(sample_depth), 32'h800);
    send(8'h04, 32'h0000_0020); chk("gain_wr", 32'(gain), 32'h20);
                                chk("depth_hold", 32'(sample_depth), 32'h800);
    send(8'h05, 32'h0000_0003); chk("chan_wr", 32'(channel), 32'h3);

    // Finite run: PERIOD=20, COUNT=3.
    send(8'h02, 32'd20);
    send(8'h03, 32'd3);
    n = cyc;
    trig_exp.push_back(n + 1); trig_exp.push_back(n + 21); trig_exp.push_back(n + 41);
    done_exp.push_back(n + 61);
    send(8'h00, 32'h1);
    chk("run_busy_start", 32'(busy), 32'd1);
    wait_cyc(n + 60); chk("run_busy_before_done", 32'(busy), 32'd1);
    wait_cyc(n + 61); chk("run_busy_fall", 32'(busy), 32'd0);
    chk("run_no_overrun", 32'(overrun), 32'd0);

    // PERIOD below minimum clamps to 16.
    send(8'h02, 32'd5);
    send(8'h03, 32'd2);
    n = cyc;
    trig_exp.push_back(n + 1); trig_exp.push_back(n + 17);
    done_exp.push_back(n + 33);
    send(8'h00, 32'h1);
    wait_cyc(n + 33); chk("clamp_busy_fall", 32'(busy), 32'd0);

    // Stall: acq_busy high over the second trigger's due cycle.
    send(8'h02, 32'd20);
    send(8'h03, 32'd3);
    n = cyc;
    trig_exp.push_back(n + 1); trig_exp.push_back(n + 26); trig_exp.push_back(n + 46);
    done_exp.push_back(n + 66);
    send(8'h00, 32'h1);
    wait_cyc(n + 19); acq_busy = 1'b1;
    wait_cyc(n + 20); chk("stall_overrun_pre", 32'(overrun), 32'd0);
    wait_cyc(n + 21); chk("stall_overrun_set", 32'(overrun), 32'd1);
    wait_cyc(n + 25); acq_busy = 1'b0;
    wait_cyc(n + 65); chk("stall_busy_pre", 32'(busy), 32'd1);
    wait_cyc(n + 66); chk("stall_busy_fall", 32'(busy), 32'd0);
    chk("stall_overrun_sticky", 32'(overrun), 32'd1);

    // Continuous run, stopped after 100 cycles.
    send(8'h03, 32'd0);
    n = cyc;
    for (int k = 0; k < 5; k++) trig_exp.push_back(n + 1 + 20 * k);
    send(8'h00, 32'h1);
    chk("cont_overrun_clr", 32'(overrun), 32'd0);
    wait_cyc(n + 100);
    send(8'h00, 32'h2);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_trig", 32'(trig), 32'd0);
    wait_cyc(n + 130);
    send(8'h00, 32'h3);
    chk("startstop_idle", 32'(busy), 32'd0);
    wait_cyc(cyc + 5);
    chk("startstop_idle_late", 32'(busy), 32'd0);

    // Rejected commands while busy, then async reset mid-run.
    n = cyc;
    trig_exp.push_back(n + 1); trig_exp.push_back(n + 21);
    err_exp.push_back(n + 2); err_exp.push_back(n + 3); err_exp.push_back(n + 4);
    send(8'h00, 32'h1);
    send(8'h02, 32'd5);
    send(8'h07, 32'h0);
    send(8'h00, 32'h1);
    send(8'h00, 32'h0);
    chk("nop_busy", 32'(busy), 32'd1);
    wait_cyc(n + 25);
    #2 Reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    wait_cyc(cyc + 5);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("trig_exp_empty", 32'(trig_exp.size()), 32'd0);
    chk("done_exp_empty", 32'(done_exp.size()), 32'd0);
    chk("err_exp_empty",  32'(err_exp.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
